// File: rtl/packet_integrator.sv
// Coherent packet integrator: accumulates M = 2**k receiver packets bin by bin
// in an internal RAM and emits the scaled sum (the average) while the last
// packet streams through. The accumulate path is a 3-stage read-modify-write
// pipeline: beat capture, RAM read, add + RAM write + output register.
//
// Stream handshake: a beat exists for exactly the one cycle its Valid is high;
// there is no back-pressure. Input beats must be at least 3 cycles apart, and
// a closer beat is an overrun. opPacket.Valid is a single-cycle pulse.

package packet_integrator_pkg;
  typedef struct packed {
    logic        SoP;
    logic        EoP;
    logic [13:0] Data;
    logic        Valid;
  } packet_t;
endpackage

module packet_integrator
  import packet_integrator_pkg::*;
#(
  parameter int N        = 2500,
  parameter int MAX_LOG2 = 8
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [3:0] ipLog2Count,
  input  packet_t    ipPacket,
  output packet_t    opPacket,
  output logic       opBusy,
  output logic       opError,
  output logic       opDbgState
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam int AW = 14 + MAX_LOG2;
  localparam logic [NW-1:0] LAST_BIN = NW'(N - 1);

  typedef enum logic {IDLE = 1'b0, INTEG = 1'b1} state_e;

  // Index of the final packet, M-1 = 2**k - 1.
  function automatic logic [MW-1:0] last_m(input logic [3:0] k);
    return MW'(((MW + 1)'(1) << k) - (MW + 1)'(1));
  endfunction

  state_e          state_q, state_d;
  logic [3:0]      k_q, k_d, k_in, proc_k;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   n_q, n_d, proc_n;
  logic [1:0]      gap_q, gap_d;
  logic            err_q, err_d;
  logic            start, proc, proc_first, proc_last;

  // Pipeline stage 1 (captured beat) and stage 2 (beat + RAM read data).
  logic            v1_q, v2_q, first1_q, first2_q, last1_q, last2_q;
  logic [NW-1:0]   n1_q, n2_q;
  logic [13:0]     s1_q, s2_q;
  logic [3:0]      k1_q, k2_q;
  logic signed [AW-1:0] rd_q, acc_w, sum_w;
  logic signed [AW-1:0] ram [N];
  packet_t         op_q;

  assign k_in = (ipLog2Count > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : ipLog2Count;

  // State register and framing counters.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q <= IDLE;
      k_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      n_q     <= n_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Next-state: beat classification (start, accumulate, ignore, fault).
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    m_d        = m_q;
    n_d        = n_q;
    gap_d      = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
    err_d      = 1'b0;
    start      = 1'b0;
    proc       = 1'b0;
    proc_n     = n_q;
    proc_k     = k_q;
    proc_first = (m_q == '0);
    proc_last  = (m_q == last_m(k_q));
    if (ipPacket.Valid && gap_q != 2'd0) begin
      // Overrun: drop the beat and abandon the integration.
      err_d   = 1'b1;
      state_d = IDLE;
      m_d     = '0;
      n_d     = '0;
    end else if (ipPacket.Valid) begin
      if (state_q == IDLE) begin
        start = ipPacket.SoP;
      end else if (ipPacket.SoP || n_q != '0) begin
        // Between packets (n=0) only a SoP beat is taken.
        if ((ipPacket.SoP && n_q != '0) ||
            (ipPacket.EoP != (n_q == LAST_BIN))) begin
          err_d   = 1'b1;
          state_d = IDLE;
          m_d     = '0;
          n_d     = '0;
          start   = ipPacket.SoP;
        end else begin
          proc = 1'b1;
        end
      end
    end
    if (start) begin
      state_d    = INTEG;
      k_d        = k_in;
      proc       = 1'b1;
      proc_n     = '0;
      proc_k     = k_in;
      proc_first = 1'b1;
      proc_last  = (last_m(k_in) == '0);
    end
    if (proc) begin
      gap_d = 2'd2;
      if (proc_n == LAST_BIN) begin
        n_d = '0;
        if (proc_last) begin
          state_d = IDLE;
          m_d     = '0;
        end else begin
          m_d = start ? MW'(1) : m_q + MW'(1);
        end
      end else begin
        n_d = proc_n + NW'(1);
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    opBusy     = (state_q == INTEG);
    opError    = err_q;
    opDbgState = state_q;
  end

  // Accumulate pipeline control and output beat register.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      v1_q <= 1'b0; n1_q <= '0; s1_q <= '0; first1_q <= 1'b0; last1_q <= 1'b0; k1_q <= '0;
      v2_q <= 1'b0; n2_q <= '0; s2_q <= '0; first2_q <= 1'b0; last2_q <= 1'b0; k2_q <= '0;
      op_q <= '0;
    end else begin
      v1_q     <= proc;
      n1_q     <= proc_n;
      s1_q     <= ipPacket.Data;
      first1_q <= proc_first;
      last1_q  <= proc_last;
      k1_q     <= proc_k;
      v2_q     <= v1_q;
      n2_q     <= n1_q;
      s2_q     <= s1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      k2_q     <= k1_q;
      op_q.Valid <= v2_q && last2_q;
      if (v2_q && last2_q) begin
        op_q.SoP  <= (n2_q == '0);
        op_q.EoP  <= (n2_q == LAST_BIN);
        op_q.Data <= 14'(sum_w >>> k2_q);
      end
    end
  end

  // The first packet overwrites its bin, so the RAM never needs clearing.
  always_comb begin
    acc_w = first2_q ? '0 : rd_q;
    sum_w = acc_w + AW'($signed(s2_q));
  end

  // Accumulator RAM: registered read in stage 2, write in stage 3.
  always_ff @(posedge ipClk) begin
    rd_q <= ram[n1_q];
    if (v2_q) begin
      ram[n2_q] <= sum_w;
    end
  end

  assign opPacket = op_q;

endmodule

// File: tb/tb_packet_integrator.sv
// Directed bench for packet_integrator with a reduced packet length.
module tb_packet_integrator;
  import packet_integrator_pkg::*;

  localparam int N = 16;
  localparam int MAX_LOG2 = 8;

  // ---------------- clock / reset ----------------
  logic       ipClk = 1'b0;
  logic       ipReset;
  logic [3:0] ipLog2Count;
  packet_t    ipPacket, opPacket;
  logic       opBusy, opError, opDbgState;

  always #5 ipClk = ~ipClk;

  packet_integrator #(.N(N), .MAX_LOG2(MAX_LOG2)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipLog2Count(ipLog2Count),
    .ipPacket(ipPacket), .opPacket(opPacket), .opBusy(opBusy),
    .opError(opError), .opDbgState(opDbgState)
  );

  logic [31:0] cyc = 32'd0;
  always @(posedge ipClk) cyc <= cyc + 32'd1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int err_pulses = 0;
  logic [47:0] exp_q[$];   // {SoP, EoP, Data, arrival cycle}

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge ipClk) begin
    if (opError) err_pulses++;
    if (opPacket.Valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h, expected no beat (t=%0t)",
                 {opPacket.SoP, opPacket.EoP, opPacket.Data}, $time);
      end else begin
        check("out_beat", {opPacket.SoP, opPacket.EoP, opPacket.Data, cyc}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // A beat driven here is sampled at edge C = cyc+1; its output must occupy
  // the cycle ending at edge C+3, i.e. be seen at the negedge where cyc = C+2.
  task automatic send_beat(input logic sop, input logic eop, input logic [13:0] d,
                           input bit want, input logic [13:0] ed, input int gap);
    @(negedge ipClk);
    ipPacket = '{SoP: sop, EoP: eop, Data: d, Valid: 1'b1};
    if (want) exp_q.push_back({sop, eop, ed, cyc + 32'd3});
    @(negedge ipClk);
    ipPacket = '0;
    repeat (gap - 2) @(negedge ipClk);
  endtask

  task automatic settle(input int c);
    repeat (c) @(negedge ipClk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  k;
    logic [13:0] ae, ao;   // even packets: even bins / odd bins
    logic [13:0] be, bo;   // odd packets:  even bins / odd bins
    logic [13:0] ee, eo;   // expected output: even bins / odd bins
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int m;
    int e0;
    logic [13:0] d, ed;
    m  = 1 << ((v.k > 4'd8) ? 8 : int'(v.k));
    e0 = err_pulses;
    ipLog2Count = v.k;
    for (int p = 0; p < m; p++) begin
      for (int b = 0; b < N; b++) begin
        if (p % 2 == 0) d = (b % 2 == 0) ? v.ae : v.ao;
        else            d = (b % 2 == 0) ? v.be : v.bo;
        ed = (b % 2 == 0) ? v.ee : v.eo;
        send_beat(b == 0, b == N - 1, d, p == m - 1, ed, 4);
        if (p == 0 && b == 0) begin
          // Changing the count mid-integration must not matter.
          ipLog2Count = 4'($urandom_range(0, 15));
          #1 check("busy_during", 48'(opBusy), 48'd1);
        end
      end
    end
    settle(6);
    check("drained", 48'(exp_q.size()), 48'd0);
    check("busy_after", 48'(opBusy), 48'd0);
    check("no_error", 48'(err_pulses), 48'(e0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int e0;
    ipReset = 1'b1;
    ipPacket = '0;
    ipLog2Count = '0;
    vecs[0] = '{k: 4'd0, ae: 14'd5,     ao: 14'h3FFF, be: 14'd0,     bo: 14'd0,     ee: 14'd5,     eo: 14'h3FFF};
    vecs[1] = '{k: 4'd0, ae: 14'h1FFF,  ao: 14'h2000, be: 14'd0,     bo: 14'd0,     ee: 14'h1FFF,  eo: 14'h2000};
    vecs[2] = '{k: 4'd1, ae: 14'd100,   ao: 14'h3FFD, be: 14'd200,   bo: 14'd0,     ee: 14'd150,   eo: 14'h3FFE};
    vecs[3] = '{k: 4'd2, ae: 14'd100,   ao: 14'd100,  be: 14'd100,   bo: 14'd100,   ee: 14'd100,   eo: 14'd100};
    vecs[4] = '{k: 4'd2, ae: 14'd7,     ao: 14'h3FF9, be: 14'd2,     bo: 14'h3FFE,  ee: 14'd4,     eo: 14'h3FFB};
    vecs[5] = '{k: 4'd3, ae: 14'h2000,  ao: 14'h1FFF, be: 14'h2000,  bo: 14'h1FFF,  ee: 14'h2000,  eo: 14'h1FFF};
    vecs[6] = '{k: 4'd9, ae: 14'd1,     ao: 14'h3FFF, be: 14'd3,     bo: 14'd0,     ee: 14'd2,     eo: 14'h3FFF};

    settle(3);
    check("reset_packet", 48'(opPacket), 48'd0);
    check("reset_busy", 48'(opBusy), 48'd0);
    check("reset_error", 48'(opError), 48'd0);
    ipReset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // SoP in mid-packet: fault, then restart with that beat as bin 0.
    ipLog2Count = 4'd0;
    e0 = err_pulses;
    for (int b = 0; b < 5; b++) send_beat(b == 0, 1'b0, 14'(b * 3 + 1), 1, 14'(b * 3 + 1), 4);
    send_beat(1'b1, 1'b0, 14'h0ABC, 1, 14'h0ABC, 4);
    for (int b = 1; b < N; b++) send_beat(1'b0, b == N - 1, 14'(b * 5), 1, 14'(b * 5), 4);
    settle(6);
    check("restart_drained", 48'(exp_q.size()), 48'd0);
    check("restart_error", 48'(err_pulses), 48'(e0 + 1));
    check("restart_busy", 48'(opBusy), 48'd0);

    // Early EoP in the final packet of a k=1 integration.
    ipLog2Count = 4'd1;
    e0 = err_pulses;
    for (int b = 0; b < N; b++) send_beat(b == 0, b == N - 1, 14'd10, 0, 14'd0, 4);
    for (int b = 0; b < 5; b++) send_beat(b == 0, 1'b0, 14'd30, 1, 14'd20, 4);
    send_beat(1'b0, 1'b1, 14'd30, 0, 14'd0, 4);
    settle(6);
    check("frame_error", 48'(err_pulses), 48'(e0 + 1));
    check("frame_busy", 48'(opBusy), 48'd0);
    check("frame_drained", 48'(exp_q.size()), 48'd0);
    run_vec(vecs[2]);

    // Overrun: second beat 2 cycles after the first.
    ipLog2Count = 4'd1;
    e0 = err_pulses;
    send_beat(1'b1, 1'b0, 14'd50, 0, 14'd0, 2);
    send_beat(1'b0, 1'b0, 14'd60, 0, 14'd0, 4);
    settle(4);
    check("overrun_error", 48'(err_pulses), 48'(e0 + 1));
    check("overrun_busy", 48'(opBusy), 48'd0);
    send_beat(1'b0, 1'b0, 14'd1, 0, 14'd0, 4);
    settle(2);
    check("idle_ignores_non_sop", 48'(opBusy), 48'd0);

    // Reset in the final packet with a beat in flight.
    ipLog2Count = 4'd1;
    for (int b = 0; b < N; b++) send_beat(b == 0, b == N - 1, 14'd40, 0, 14'd0, 4);
    for (int b = 0; b < 12; b++) send_beat(b == 0, 1'b0, 14'd60, 1, 14'd50, 4);
    @(negedge ipClk);
    ipPacket = '{SoP: 1'b0, EoP: 1'b0, Data: 14'd60, Valid: 1'b1};
    @(posedge ipClk);
    #1 ipReset = 1'b1;
    #1;
    ipPacket = '0;
    check("midreset_packet", 48'(opPacket), 48'd0);
    check("midreset_busy", 48'(opBusy), 48'd0);
    settle(2);
    ipReset = 1'b0;
    settle(8);
    check("midreset_drained", 48'(exp_q.size()), 48'd0);
    send_beat(1'b0, 1'b0, 14'd7, 0, 14'd0, 4);
    settle(1);
    check("after_reset_needs_sop", 48'(opBusy), 48'd0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
